// File: rtl/oled_spi_sink.sv
// SSD1306-style 4-wire SPI sink: decodes OLED commands into a register set and
// emits framebuffer write strobes. Define OLED_SPI_SINK_STATS_EN to add byte counters.
module oled_spi_sink #(
  parameter int SYNC_STAGES = 0,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ioSclk,
  input  logic                  ioSdin,
  input  logic                  ioCs,
  input  logic                  ioDc,
  output logic                  pixelWriteEn,
  output logic [ADDR_WIDTH-1:0] pixelWriteAddress,
  output logic [7:0]            pixelWriteData,
  output logic                  displayOn,
  output logic [7:0]            contrast,
  output logic [1:0]            addrMode,
  output logic                  invert,
  output logic                  chargePump,
  output logic [5:0]            muxRatio,
  output logic                  cmdError
`ifdef OLED_SPI_SINK_STATS_EN
  ,
  output logic [15:0]           cmdCount,
  output logic [15:0]           dataCount
`endif
);

  typedef enum logic {CMD_IDLE, CMD_PARAM} cmdState_t;

  // Idle bus: sclk high, cs deasserted. Order is {sclk, sdin, cs, dc}.
  localparam logic [3:0] SYNC_RESET = 4'b1010;

  // Stage p0: input register plus optional synchronizer flops
  logic [3:0] inSync_p0 [SYNC_STAGES+1];
  logic       sclkSync, sdinSync, csSync, dcSync;
  logic       sclkPrev, sclkRise;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= SYNC_STAGES; i++) inSync_p0[i] <= SYNC_RESET;
      sclkPrev <= 1'b1;
    end else begin
      inSync_p0[0] <= {ioSclk, ioSdin, ioCs, ioDc};
      for (int i = 1; i <= SYNC_STAGES; i++) inSync_p0[i] <= inSync_p0[i-1];
      sclkPrev <= sclkSync;
    end
  end

  assign {sclkSync, sdinSync, csSync, dcSync} = inSync_p0[SYNC_STAGES];
  assign sclkRise = sclkSync & ~sclkPrev;

  // Stage p1: bit shifter, byte-complete pulse
  logic [6:0] shiftReg;
  logic [2:0] bitCount;
  logic       vld_p1;
  logic [7:0] byte_p1;
  logic       dc_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      bitCount <= 3'd0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (csSync) begin
        bitCount <= 3'd0;
      end else if (sclkRise) begin
        bitCount <= bitCount + 3'd1;
        if (bitCount == 3'd7) vld_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclkRise && !csSync) begin
      shiftReg <= {shiftReg[5:0], sdinSync};
      if (bitCount == 3'd7) begin
        byte_p1 <= {shiftReg, sdinSync};
        dc_p1   <= dcSync;
      end
    end
  end

  // Stage p2: command decode and framebuffer write
  cmdState_t  cmdState, cmdStateNext;
  logic [7:0] pendingOp, pendingOpNext;
  logic       displayOnNext, invertNext, chargePumpNext, cmdErrorNext;
  logic [7:0] contrastNext;
  logic [1:0] addrModeNext;
  logic [5:0] muxRatioNext;

  always_comb begin
    cmdStateNext   = cmdState;
    pendingOpNext  = pendingOp;
    displayOnNext  = displayOn;
    invertNext     = invert;
    chargePumpNext = chargePump;
    contrastNext   = contrast;
    addrModeNext   = addrMode;
    muxRatioNext   = muxRatio;
    cmdErrorNext   = 1'b0;
    if (vld_p1 && !dc_p1) begin
      if (cmdState == CMD_PARAM) begin
        cmdStateNext = CMD_IDLE;
        case (pendingOp)
          8'h81: contrastNext = byte_p1;
          8'h20: begin
            if (byte_p1[1:0] == 2'b11) cmdErrorNext = 1'b1;
            else                       addrModeNext = byte_p1[1:0];
          end
          8'hA8: muxRatioNext   = byte_p1[5:0];
          8'h8D: chargePumpNext = byte_p1[2];
          default: ;
        endcase
      end else begin
        casez (byte_p1)
          8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D: begin
            pendingOpNext = byte_p1;
            cmdStateNext  = CMD_PARAM;
          end
          8'hAE: displayOnNext = 1'b0;
          8'hAF: displayOnNext = 1'b1;
          8'hA6: invertNext    = 1'b0;
          8'hA7: invertNext    = 1'b1;
          8'hA4, 8'hA5, 8'hA0, 8'hA1, 8'hC0, 8'hC8, 8'b01??????: ;
          default: cmdErrorNext = 1'b1;
        endcase
      end
    end
  end

  logic [ADDR_WIDTH-1:0] writePtr;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmdState     <= CMD_IDLE;
      pendingOp    <= 8'h00;
      displayOn    <= 1'b0;
      contrast     <= 8'h7F;
      addrMode     <= 2'b10;
      invert       <= 1'b0;
      chargePump   <= 1'b0;
      muxRatio     <= 6'd63;
      cmdError     <= 1'b0;
      pixelWriteEn <= 1'b0;
      writePtr     <= '0;
    end else begin
      cmdState     <= cmdStateNext;
      pendingOp    <= pendingOpNext;
      displayOn    <= displayOnNext;
      contrast     <= contrastNext;
      addrMode     <= addrModeNext;
      invert       <= invertNext;
      chargePump   <= chargePumpNext;
      muxRatio     <= muxRatioNext;
      cmdError     <= cmdErrorNext;
      pixelWriteEn <= vld_p1 && dc_p1;
      if (vld_p1 && dc_p1) writePtr <= writePtr + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1 && dc_p1) begin
      pixelWriteData    <= byte_p1;
      pixelWriteAddress <= writePtr;
    end
  end

`ifdef OLED_SPI_SINK_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cmdCount  <= 16'd0;
      dataCount <= 16'd0;
    end else if (vld_p1) begin
      if (dc_p1) begin
        if (dataCount != 16'hFFFF) dataCount <= dataCount + 16'd1;
      end else begin
        if (cmdCount != 16'hFFFF) cmdCount <= cmdCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/oled_spi_sink.md
Name: oled_spi_sink

Overview:
- SPI slave that receives the 4-wire SSD1306-style OLED stream (sclk, sdin, cs, dc) our display driver produces. It is the device end of that link.
- Command bytes (dc=0) are decoded into a small register set. Data bytes (dc=1) are emitted as framebuffer write strobes with an auto-incrementing 10-bit address.
- Used as the display model in system sims and as an on-FPGA loopback checker for the screen driver.

Parameters:
- SYNC_STAGES, 0, extra synchronizer flops on the SPI inputs beyond the mandatory input register; 0 = same clock domain as the driver, 2 = asynchronous source.
- ADDR_WIDTH, 10, framebuffer address width (128x64 / 8 = 1024 bytes).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ioSclk  in  1  SPI clock; idles high, data sampled on rising edge
- ioSdin  in  1  SPI data, MSB first
- ioCs  in  1  chip select, active low
- ioDc  in  1  0 = command byte, 1 = data byte
- pixelWriteEn  out  1  one-cycle strobe per received data byte
- pixelWriteAddress  out  ADDR_WIDTH  framebuffer address for the current strobe
- pixelWriteData  out  8  received data byte
- displayOn  out  1  set by 0xAF, cleared by 0xAE
- contrast  out  8  last 0x81 parameter
- addrMode  out  2  last valid 0x20 parameter
- invert  out  1  0xA7 sets, 0xA6 clears
- chargePump  out  1  bit 2 of the last 0x8D parameter
- muxRatio  out  6  last 0xA8 parameter, bits [5:0]
- cmdError  out  1  one-cycle pulse on an unknown opcode or an invalid parameter

Behaviour:
- All four SPI inputs pass through one input register, then SYNC_STAGES further flops. A rising edge is detected when the synced sclk is 1 and its previous value was 0. Sclk toggling every clk cycle (the driver's rate) must decode correctly with SYNC_STAGES=0.
- On each detected rising edge with synced cs=0:
  - shift sdin into shiftReg (MSB first);
  - bitCount increments, 3 bits;
  - dc is captured on the 8th bit.
- Synced cs=1 clears bitCount and discards the partial byte. The pending-parameter state is kept: the driver raises cs between a command and its parameter.
- Byte-complete pulse occurs on the cycle after the 8th edge is detected.
- Latency: pixelWriteEn asserts exactly SYNC_STAGES+2 clk cycles after the clk edge on which the 8th sclk rise is present on ioSclk.
- Data byte handling:
  - pixelWriteData = byte; pixelWriteAddress = writePtr; writePtr increments.
  - writePtr wraps from 2^ADDR_WIDTH-1 to 0.
  - Data bytes are written regardless of displayOn.
- Command FSM states: CMD_IDLE, CMD_PARAM.
  - CMD_IDLE, two-byte opcodes 0x81, 0x20, 0xA8, 0xD3, 0xD5, 0xD9, 0xDB, 0x8D: latch the opcode and go to CMD_PARAM.
  - CMD_IDLE, single-byte opcodes:
    - 0xAE/0xAF: displayOn.
    - 0xA6/0xA7: invert.
    - No-ops: 0xA4, 0xA5, 0xA0, 0xA1, 0xC0, 0xC8, 0x40-0x7F.
    - Any other opcode: cmdError pulse, stay in CMD_IDLE.
  - CMD_PARAM: the next command byte is the parameter; apply it and return to CMD_IDLE.
    - 0x20 with param[1:0]==3 leaves addrMode unchanged and pulses cmdError.
    - Parameters for 0xD3, 0xD5, 0xD9, 0xDB are accepted and discarded.
- A data byte arriving while in CMD_PARAM is written normally, and the FSM stays in CMD_PARAM.
- Reset values: all strobes 0, writePtr 0, bitCount 0, FSM CMD_IDLE, displayOn 0, contrast 0x7F, addrMode 2'b10, invert 0, chargePump 0, muxRatio 63. Synchronizer flops reset to sclk=1, cs=1, sdin=0, dc=0.
- Reset asserted mid-byte drops the byte. No strobe is issued for it.

Optional Feature:
- Macro OLED_SPI_SINK_STATS_EN.
- When defined, adds outputs cmdCount[15:0] and dataCount[15:0]. Each increments per completed command byte or data byte (parameters count as commands), saturates at 0xFFFF, and clears on reset.
- When undefined, these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Full driver init stream (23 command bytes, cs pulsed high between bytes), SYNC_STAGES=0 -> displayOn=1, contrast=0x7F, addrMode=0, muxRatio=63, chargePump=1, cmdError never asserted.
- After init, 1025 data bytes 0x00..0xFF repeating, cs held low -> 1025 strobes; addresses 0..1023 then 0 (wrap); strobe 1025 carries data 0x00; each strobe at SYNC_STAGES+2 cycles after the 8th sclk rise.
- Command 0x20, cs high, param 0x03 -> cmdError one pulse, addrMode unchanged at 2'b10; then 0x20, 0x01 -> addrMode=1.
- cs raised after 5 bits of 0xAF, then full 0xAE -> displayOn stays 0, no cmdError, no strobe.
- Opcode 0x55 then 0xB3 -> 0x55 no effect (no-op range), 0xB3 pulses cmdError once.
- SYNC_STAGES=2, sclk phases of 4 clk, reset asserted mid data byte -> no strobe, writePtr=0; next full byte 0xA5 written at address 0.
